// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit: instruction types,
// operand-mux select codes, internal forward kinds and instruction-class helpers.
package fwd_pkg;

  typedef enum logic [2:0] {
    ITYPE_ALU_RR  = 3'd0,
    ITYPE_ALU_IMM = 3'd1,
    ITYPE_LOAD    = 3'd2,
    ITYPE_STORE   = 3'd3,
    ITYPE_BRANCH  = 3'd4,
    ITYPE_NOP     = 3'd5,
    ITYPE_PP_H    = 3'd6,
    ITYPE_PP_V    = 3'd7
  } itype_e;

  typedef enum logic [1:0] {
    SRC_A_EXMEM_ALU = 2'd0,
    SRC_A_MEMWB_ALU = 2'd1,
    SRC_A_MEMWB_LD  = 2'd2,
    SRC_A_IDEX      = 2'd3
  } src_a_e;

  typedef enum logic [2:0] {
    SRC_B_IDEX      = 3'd0,
    SRC_B_IMM       = 3'd1,
    SRC_B_MEMWB_LD  = 3'd2,
    SRC_B_MEMWB_ALU = 3'd3,
    SRC_B_EXMEM_ALU = 3'd4,
    SRC_B_PP_V      = 3'd5,
    SRC_B_PP_H      = 3'd6
  } src_b_e;

  // Stage-neutral result of one source's match, mapped to mux codes by the top.
  typedef enum logic [1:0] {
    FWD_NONE   = 2'd0,
    FWD_MEM    = 2'd1,
    FWD_WB_ALU = 2'd2,
    FWD_WB_LD  = 2'd3
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  function automatic logic is_writer(input itype_e t);
    return (t inside {ITYPE_ALU_RR, ITYPE_ALU_IMM, ITYPE_LOAD});
  endfunction

  function automatic logic reads_rs(input itype_e t);
    return (t inside {ITYPE_ALU_RR, ITYPE_ALU_IMM, ITYPE_LOAD, ITYPE_STORE,
                      ITYPE_PP_H, ITYPE_PP_V});
  endfunction

  function automatic logic reads_rt(input itype_e t);
    return (t inside {ITYPE_ALU_RR, ITYPE_STORE});
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Per-source forward match: MEM beats WB, a load in MEM never forwards,
// and register 0 is ignored when ZERO_REG is set.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic [REG_AW-1:0] exmem_wba,
  input  itype_e            exmem_type,
  input  logic [REG_AW-1:0] memwb_wba,
  input  itype_e            memwb_type,
  output fwd_sel_e          sel
);

  logic src_ok;
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    src_ok  = src_used && ((ZERO_REG == 0) || (src != '0));
    mem_hit = src_ok && is_writer(exmem_type) && (exmem_type != ITYPE_LOAD) &&
              (exmem_wba == src);
    wb_hit  = src_ok && is_writer(memwb_type) && (memwb_wba == src);
    sel = FWD_NONE;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = (memwb_type == ITYPE_LOAD) ? FWD_WB_LD : FWD_WB_ALU;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding plus load-use stall FSM for the 5-stage pipeline.
// Optional activity counters are built when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ITYPE_W  = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_AW-1:0]  ifid_rs,
  input  logic [REG_AW-1:0]  ifid_rt,
  input  logic [ITYPE_W-1:0] ifid_type,
  input  logic [REG_AW-1:0]  idex_rs,
  input  logic [REG_AW-1:0]  idex_rt,
  input  logic [REG_AW-1:0]  idex_wba,
  input  logic [ITYPE_W-1:0] idex_type,
  input  logic [REG_AW-1:0]  exmem_wba,
  input  logic [ITYPE_W-1:0] exmem_type,
  input  logic [REG_AW-1:0]  memwb_wba,
  input  logic [ITYPE_W-1:0] memwb_type,
  output logic [1:0]         alu_src_a,
  output logic [2:0]         alu_src_b,
  output logic               ifid_hold,
  output logic               idex_bubble,
  output logic               stall_busy
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]        fwd_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

  // Type codes beyond the defined set behave as NOPs.
  function automatic itype_e decode_type(input logic [ITYPE_W-1:0] raw);
    logic [31:0] wide;
    wide = 32'(raw);
    if (wide > 32'd7) begin
      return ITYPE_NOP;
    end
    return itype_e'(wide[2:0]);
  endfunction

  itype_e    ifid_t, idex_t, exmem_t, memwb_t;
  fwd_sel_e  a_sel, b_sel;
  src_a_e    src_a;
  src_b_e    src_b;
  hz_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic      rs_dep, rt_dep, load_dst_ok, hazard;

  always_comb begin
    ifid_t  = decode_type(ifid_type);
    idex_t  = decode_type(idex_type);
    exmem_t = decode_type(exmem_type);
    memwb_t = decode_type(memwb_type);
  end

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_sel_a (
    .src        (idex_rs),
    .src_used   (reads_rs(idex_t)),
    .exmem_wba  (exmem_wba),
    .exmem_type (exmem_t),
    .memwb_wba  (memwb_wba),
    .memwb_type (memwb_t),
    .sel        (a_sel)
  );

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_sel_b (
    .src        (idex_rt),
    .src_used   (reads_rt(idex_t)),
    .exmem_wba  (exmem_wba),
    .exmem_type (exmem_t),
    .memwb_wba  (memwb_wba),
    .memwb_type (memwb_t),
    .sel        (b_sel)
  );

  // A store's rt match feeds its data path, so only RegReg forwards onto B.
  always_comb begin
    unique case (a_sel)
      FWD_MEM:    src_a = SRC_A_EXMEM_ALU;
      FWD_WB_ALU: src_a = SRC_A_MEMWB_ALU;
      FWD_WB_LD:  src_a = SRC_A_MEMWB_LD;
      default:    src_a = SRC_A_IDEX;
    endcase

    src_b = SRC_B_IMM;
    if ((idex_t == ITYPE_ALU_RR) && (b_sel != FWD_NONE)) begin
      unique case (b_sel)
        FWD_MEM:    src_b = SRC_B_EXMEM_ALU;
        FWD_WB_ALU: src_b = SRC_B_MEMWB_ALU;
        default:    src_b = SRC_B_MEMWB_LD;
      endcase
    end else begin
      unique case (idex_t)
        ITYPE_ALU_RR: src_b = SRC_B_IDEX;
        ITYPE_PP_H:   src_b = SRC_B_PP_H;
        ITYPE_PP_V:   src_b = SRC_B_PP_V;
        default:      src_b = SRC_B_IMM;
      endcase
    end

    alu_src_a = src_a;
    alu_src_b = src_b;
  end

  // Detection is masked in STALL and during reset so bubbles never retrigger.
  always_comb begin
    rs_dep      = reads_rs(ifid_t) && (ifid_rs == idex_wba);
    rt_dep      = reads_rt(ifid_t) && (ifid_rt == idex_wba);
    load_dst_ok = (idex_t == ITYPE_LOAD) && ((ZERO_REG == 0) || (idex_wba != '0));
    hazard      = rst_n && (state_q == ST_RUN) && load_dst_ok && (rs_dep || rt_dep);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The detecting cycle is the first stall cycle, so STALL covers LOAD_LAT-1 more.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (hazard && (LOAD_LAT > 1)) begin
          state_d = ST_STALL;
          cnt_d   = CNT_INIT;
        end
      end
      ST_STALL: begin
        if (cnt_q <= 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_busy  = (state_q == ST_STALL);
    ifid_hold   = hazard || stall_busy;
    idex_bubble = hazard || stall_busy;
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        fwd_any;

  // Counters saturate rather than wrap.
  always_comb begin
    fwd_any = (src_a != SRC_A_IDEX) ||
              (src_b inside {SRC_B_MEMWB_LD, SRC_B_MEMWB_ALU, SRC_B_EXMEM_ALU});
    fwd_cnt_d = fwd_cnt_q;
    if (fwd_any && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
    stall_cnt_d = stall_cnt_q;
    if (ifid_hold && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    fwd_cnt   = fwd_cnt_q;
    stall_cnt = stall_cnt_q;
  end
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational forwarding unit of the 5-stage pipeline.
- Combines three functions:
  - ALU operand forwarding for EX.
  - A load-use hazard FSM that stalls IF/ID and injects bubbles into ID/EX for a configurable load latency.
  - An r0 guard.
- Sits beside the ID/EX register; drives the EX operand muxes and the pipeline-register enable/flush controls.

Parameters:
- REG_AW, 5, register-address width (register count = 2**REG_AW).
- ITYPE_W, 3, instruction-type field width.
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7).
- ZERO_REG, 1, when 1, register 0 is never a forward/hazard source.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ifid_rs  in  REG_AW  source A of instruction in ID
- ifid_rt  in  REG_AW  source B of instruction in ID
- ifid_type  in  ITYPE_W  type of instruction in ID
- idex_rs  in  REG_AW  source A of instruction in EX
- idex_rt  in  REG_AW  source B of instruction in EX
- idex_wba  in  REG_AW  destination of instruction in EX
- idex_type  in  ITYPE_W  type of instruction in EX
- exmem_wba  in  REG_AW  MEM-stage destination
- exmem_type  in  ITYPE_W  MEM-stage type
- memwb_wba  in  REG_AW  WB-stage destination
- memwb_type  in  ITYPE_W  WB-stage type
- alu_src_a  out  2  A mux select
- alu_src_b  out  3  B mux select
- ifid_hold  out  1  freeze PC and IF/ID
- idex_bubble  out  1  load NOP into ID/EX
- stall_busy  out  1  FSM not in RUN

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Instruction types:
  - 0 RegReg ALU; 1 ALUimm; 2 Load; 3 Store; 4 Branch; 5 NOP; 6 PP horizontal move; 7 PP vertical move.
  - Writers: 0, 1, 2. Readers of rs: 0, 1, 2, 3, 6, 7. Readers of rt: 0 and 3 only.
- alu_src_a encoding: 0 EX/MEM ALU result, 1 MEM/WB ALU result, 2 MEM/WB load data, 3 ID/EX A.
- alu_src_b encoding: 0 ID/EX B, 1 immediate, 2 MEM/WB load data, 3 MEM/WB ALU result, 4 EX/MEM ALU result, 5 vertical PP offset, 6 horizontal PP offset.
- Forwarding (combinational, same cycle):
  - MEM match has priority over WB match.
  - A MEM-stage Load (type 2) never forwards from MEM; that case is covered by the stall.
  - WB forward selects the load-data code if memwb_type==2, else the ALU code.
  - A source with address 0 never matches when ZERO_REG=1.
  - No match: A=3. B follows idex_type: 0→0; 1,2,3→1; 6→6; 7→5; others→1.
  - Store (type 3) uses forward codes on rt only for its data path; the B operand is still the immediate (1).
- Load-use FSM, states RUN and STALL, with a 3-bit counter cnt:
  - RUN→STALL when idex_type==2, idex_wba is non-zero (or ZERO_REG=0), and the ID instruction reads idex_wba on a used source. On that transition cnt loads LOAD_LAT-1.
  - STALL: ifid_hold=1 and idex_bubble=1 every cycle; cnt decrements; exit to RUN when cnt==0.
  - Hazard detection is gated off in STALL, so a bubble cannot retrigger.
  - In RUN, ifid_hold and idex_bubble are combinationally 1 in the detecting cycle. The total stall is exactly LOAD_LAT cycles.
  - stall_busy=1 in STALL only.
- Reset (rst_n low, async):
  - State RUN, cnt=0.
  - Outputs ifid_hold=0, idex_bubble=0, stall_busy=0.
  - alu_src_a=3, alu_src_b=0 while all inputs are zero.
  - Reset asserted mid-stall aborts the stall immediately. No stall resumes after release.
- Simultaneous MEM and WB matches on both sources: MEM wins independently per source.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- When defined, adds:
  - Output ports fwd_cnt[31:0] and stall_cnt[31:0].
  - fwd_cnt increments once per cycle in which either source is forwarded.
  - stall_cnt increments every cycle ifid_hold=1.
  - Both saturate at all-ones and clear on reset.
- When undefined, neither port nor logic exists.

Decomposition:
- Package fwd_pkg holds:
  - Instruction-type enum (ITYPE_ALU_RR … ITYPE_PP_V).
  - Enums for the alu_src_a and alu_src_b codes.
  - Functions is_writer, reads_rs and reads_rt.
- Sub-module fwd_select: pure combinational per-source match and priority, instantiated twice (A and B). The B wrapper adds the type-based default.
- The FSM and counters live in the top module.

Test Plan:
- WB RegReg, memwb_wba=1, idex_rs=idex_rt=1, idex_type=0 → A=1, B=3. Same with memwb_type=2 → A=2, B=2.
- MEM and WB both target r1, all RegReg → A=0, B=4. Then memwb_wba=2, idex_rt=2, memwb_type=2 → A=0, B=2.
- r0 guard, exmem_wba=0, idex_rs=0, ZERO_REG=1 → A=3. No stall when a load to r0 is followed by a reader of r0.
- LOAD_LAT=3: idex_type=2, idex_wba=5, ifid_rs=5 → ifid_hold=1 for exactly 3 cycles, stall_busy=1 for cycles 2–3, then RUN.
- No match with idex_type 0/1/2/3/6/7 → A=3 and B=0/1/1/1/6/5 respectively.
- rst_n driven low during cycle 2 of a LOAD_LAT=3 stall → ifid_hold and idex_bubble go to 0 asynchronously and stay 0 after release. With FWD_HAZARD_STATS_EN defined, stall_cnt reads 0 after reset.
